// File: rtl/conv_pkg.sv
// Shared constants and types for the conv2 front end.
package conv_pkg;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned KERNEL      = 3;
  localparam int unsigned WIN_N       = KERNEL * KERNEL;
  localparam int unsigned CONV2_IMG_W = 14;
  localparam int unsigned CONV2_IMG_H = 14;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t window_t [0:WIN_N-1];
endpackage

// File: rtl/conv_line_buf.sv
// Enabled shift buffer: dout is din delayed by DEPTH enabled cycles.
module conv_line_buf #(
  parameter int unsigned DEPTH  = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  import conv_pkg::*;

  logic [DATA_W-1:0] sr [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '{default: '0};
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/conv2_window_gen.sv
// Raster-stream 3x3 window generator (stride 1, no padding) feeding the conv2 filter bank.
module conv2_window_gen #(
  parameter int unsigned IMG_W  = conv_pkg::CONV2_IMG_W,
  parameter int unsigned IMG_H  = conv_pkg::CONV2_IMG_H,
  parameter int unsigned DATA_W = conv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] data_out [0:8],
  output logic              out_valid,
  output logic              frame_done
);
  import conv_pkg::*;

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] lb0_out;
  logic [DATA_W-1:0] lb1_out;
  logic [DATA_W-1:0] win_q [0:8];
  logic [DATA_W-1:0] win_d [0:8];
  logic              col_last;
  logic              row_last;
  logic              emit;

  // LB0 holds the previous row, LB1 the row before that.
  conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (in_data),
    .dout (lb0_out)
  );

  conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign emit     = in_valid && (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));

  // Next window: shift every row left, new right column from the line buffers and input.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_out;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_out;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '{default: '0};
      data_out   <= '{default: '0};
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && col_last && row_last;
      if (in_valid) begin
        win_q <= win_d;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      // Output words only change when a valid window is emitted.
      if (emit) begin
        data_out <= win_d;
      end
    end
  end
endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen: a 5x5 instance and a default 14x14 instance.
module tb_conv2_window_gen;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic              rst5 = 1'b1;
  logic              v5   = 1'b0;
  logic [DATA_W-1:0] din5 = '0;
  window_t           dout5;
  logic              ov5;
  logic              fd5;

  logic              rst14 = 1'b1;
  logic              v14   = 1'b0;
  logic [DATA_W-1:0] din14 = '0;
  window_t           dout14;
  logic              ov14;
  logic              fd14;

  conv2_window_gen #(.IMG_W(5), .IMG_H(5), .DATA_W(DATA_W)) dut5 (
    .clk        (clk),
    .rst        (rst5),
    .in_valid   (v5),
    .in_data    (din5),
    .data_out   (dout5),
    .out_valid  (ov5),
    .frame_done (fd5)
  );

  conv2_window_gen dut14 (
    .clk        (clk),
    .rst        (rst14),
    .in_valid   (v14),
    .in_data    (din14),
    .data_out   (dout14),
    .out_valid  (ov14),
    .frame_done (fd14)
  );

  // Expected word k of the window ending at pixel (r,c); pixel value = base + row*16 + col.
  function automatic logic [DATA_W-1:0] exp_word(input int base, input int r, input int c, input int k);
    return DATA_W'(base + (r - 2 + k / 3) * 16 + (c - 2 + k % 3));
  endfunction

  task automatic cyc5(input logic v, input logic [DATA_W-1:0] d);
    v5 = v;
    din5 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc14(input logic v, input logic [DATA_W-1:0] d);
    v14 = v;
    din14 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst5 = 1'b1;
    rst14 = 1'b1;
    v14 = 1'b1;
    din14 = 32'h77;
    for (int i = 0; i < 3; i++) cyc5(1'b1, 32'h55);
    vectors++;
    if (ov5 !== 1'b0) begin miscompares++; $display("FAIL reset_ov5: got %b want 0", ov5); end
    vectors++;
    if (fd5 !== 1'b0) begin miscompares++; $display("FAIL reset_fd5: got %b want 0", fd5); end
    vectors++;
    if (ov14 !== 1'b0) begin miscompares++; $display("FAIL reset_ov14: got %b want 0", ov14); end
    vectors++;
    if (fd14 !== 1'b0) begin miscompares++; $display("FAIL reset_fd14: got %b want 0", fd14); end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (dout5[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_dout5[%0d]: got %h want 0", k, dout5[k]);
      end
    end
    rst5 = 1'b0;
    rst14 = 1'b0;
    v14 = 1'b0;
    cyc5(1'b0, '0);
  endtask

  task automatic test_continuous();
    int  wins;
    logic ev, ef;
    wins = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        ev = (r >= 2) && (c >= 2);
        ef = (r == 4) && (c == 4);
        cyc5(1'b1, DATA_W'(r * 16 + c));
        if (ov5 === 1'b1) wins++;
        vectors++;
        if (ov5 !== ev) begin miscompares++; $display("FAIL cont_ov (%0d,%0d): got %b want %b", r, c, ov5, ev); end
        vectors++;
        if (fd5 !== ef) begin miscompares++; $display("FAIL cont_fd (%0d,%0d): got %b want %b", r, c, fd5, ef); end
        if (ev) begin
          for (int k = 0; k < 9; k++) begin
            vectors++;
            if (dout5[k] !== exp_word(0, r, c, k)) begin
              miscompares++;
              $display("FAIL cont_win (%0d,%0d)[%0d]: got %h want %h", r, c, k, dout5[k], exp_word(0, r, c, k));
            end
          end
        end
      end
    end
    cyc5(1'b0, 32'hdead);
    vectors++;
    if (ov5 !== 1'b0) begin miscompares++; $display("FAIL cont_idle_ov: got %b want 0", ov5); end
    vectors++;
    if (wins != 9) begin miscompares++; $display("FAIL cont_count: got %0d want 9", wins); end
  endtask

  task automatic test_gaps();
    int  wins, ng, lr, lc;
    logic ev, ef;
    wins = 0;
    lr = 4;
    lc = 4;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        ng = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
        for (int g = 0; g < ng; g++) begin
          cyc5(1'b0, 32'hdead_beef);
          vectors++;
          if (ov5 !== 1'b0) begin miscompares++; $display("FAIL gap_ov (%0d,%0d): got %b want 0", r, c, ov5); end
          vectors++;
          if (fd5 !== 1'b0) begin miscompares++; $display("FAIL gap_fd (%0d,%0d): got %b want 0", r, c, fd5); end
          for (int k = 0; k < 9; k++) begin
            vectors++;
            if (dout5[k] !== exp_word(0, lr, lc, k)) begin
              miscompares++;
              $display("FAIL gap_hold (%0d,%0d)[%0d]: got %h want %h", r, c, k, dout5[k], exp_word(0, lr, lc, k));
            end
          end
        end
        ev = (r >= 2) && (c >= 2);
        ef = (r == 4) && (c == 4);
        cyc5(1'b1, DATA_W'(r * 16 + c));
        if (ov5 === 1'b1) wins++;
        vectors++;
        if (ov5 !== ev) begin miscompares++; $display("FAIL gap_pix_ov (%0d,%0d): got %b want %b", r, c, ov5, ev); end
        vectors++;
        if (fd5 !== ef) begin miscompares++; $display("FAIL gap_pix_fd (%0d,%0d): got %b want %b", r, c, fd5, ef); end
        if (ev) begin
          lr = r;
          lc = c;
          for (int k = 0; k < 9; k++) begin
            vectors++;
            if (dout5[k] !== exp_word(0, r, c, k)) begin
              miscompares++;
              $display("FAIL gap_win (%0d,%0d)[%0d]: got %h want %h", r, c, k, dout5[k], exp_word(0, r, c, k));
            end
          end
        end
      end
    end
    vectors++;
    if (wins != 9) begin miscompares++; $display("FAIL gap_count: got %0d want 9", wins); end
  endtask

  task automatic test_back_to_back();
    int  wins, fds, base;
    logic ev, ef;
    wins = 0;
    fds = 0;
    for (int f = 0; f < 2; f++) begin
      base = (f == 0) ? 0 : 32'h100;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          ev = (r >= 2) && (c >= 2);
          ef = (r == 4) && (c == 4);
          cyc5(1'b1, DATA_W'(base + r * 16 + c));
          if (ov5 === 1'b1) wins++;
          if (fd5 === 1'b1) fds++;
          vectors++;
          if (ov5 !== ev) begin miscompares++; $display("FAIL b2b_ov f%0d (%0d,%0d): got %b want %b", f, r, c, ov5, ev); end
          vectors++;
          if (fd5 !== ef) begin miscompares++; $display("FAIL b2b_fd f%0d (%0d,%0d): got %b want %b", f, r, c, fd5, ef); end
          if (ev) begin
            for (int k = 0; k < 9; k++) begin
              vectors++;
              if (dout5[k] !== exp_word(base, r, c, k)) begin
                miscompares++;
                $display("FAIL b2b_win f%0d (%0d,%0d)[%0d]: got %h want %h", f, r, c, k, dout5[k], exp_word(base, r, c, k));
              end
            end
          end
        end
      end
    end
    cyc5(1'b0, '0);
    vectors++;
    if (wins != 18) begin miscompares++; $display("FAIL b2b_count: got %0d want 18", wins); end
    vectors++;
    if (fds != 2) begin miscompares++; $display("FAIL b2b_frames: got %0d want 2", fds); end
  endtask

  task automatic test_reset_midframe();
    int  wins, fds;
    logic ev, ef;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (!(r == 3 && c >= 2)) cyc5(1'b1, DATA_W'(32'h200 + r * 16 + c));
      end
    end
    // Reset lands on the cycle that would otherwise emit window (3,2).
    rst5 = 1'b1;
    cyc5(1'b1, 32'h232);
    rst5 = 1'b0;
    vectors++;
    if (ov5 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ov: got %b want 0", ov5); end
    vectors++;
    if (fd5 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_fd: got %b want 0", fd5); end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (dout5[k] !== '0) begin miscompares++; $display("FAIL mid_rst_dout[%0d]: got %h want 0", k, dout5[k]); end
    end
    wins = 0;
    fds = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        ev = (r >= 2) && (c >= 2);
        ef = (r == 4) && (c == 4);
        cyc5(1'b1, DATA_W'(32'h300 + r * 16 + c));
        if (ov5 === 1'b1) wins++;
        if (fd5 === 1'b1) fds++;
        vectors++;
        if (ov5 !== ev) begin miscompares++; $display("FAIL mid_ov (%0d,%0d): got %b want %b", r, c, ov5, ev); end
        if (ev) begin
          for (int k = 0; k < 9; k++) begin
            vectors++;
            if (dout5[k] !== exp_word(32'h300, r, c, k)) begin
              miscompares++;
              $display("FAIL mid_win (%0d,%0d)[%0d]: got %h want %h", r, c, k, dout5[k], exp_word(32'h300, r, c, k));
            end
          end
        end
      end
    end
    cyc5(1'b0, '0);
    vectors++;
    if (wins != 9) begin miscompares++; $display("FAIL mid_count: got %0d want 9", wins); end
    vectors++;
    if (fds != 1) begin miscompares++; $display("FAIL mid_frames: got %0d want 1", fds); end
  endtask

  task automatic test_default_14();
    int  wins, fds, base;
    logic ev, ef;
    wins = 0;
    fds = 0;
    for (int f = 0; f < 2; f++) begin
      base = (f == 0) ? 0 : 32'h1000;
      for (int r = 0; r < 14; r++) begin
        for (int c = 0; c < 14; c++) begin
          ev = (r >= 2) && (c >= 2);
          ef = (r == 13) && (c == 13);
          cyc14(1'b1, DATA_W'(base + r * 16 + c));
          if (ov14 === 1'b1) wins++;
          if (fd14 === 1'b1) fds++;
          vectors++;
          if (fd14 !== ef) begin miscompares++; $display("FAIL d14_fd f%0d (%0d,%0d): got %b want %b", f, r, c, fd14, ef); end
          if (ev) begin
            for (int k = 0; k < 9; k++) begin
              vectors++;
              if (dout14[k] !== exp_word(base, r, c, k)) begin
                miscompares++;
                $display("FAIL d14_win f%0d (%0d,%0d)[%0d]: got %h want %h", f, r, c, k, dout14[k], exp_word(base, r, c, k));
              end
            end
          end
        end
      end
    end
    cyc14(1'b0, '0);
    vectors++;
    if (wins != 288) begin miscompares++; $display("FAIL d14_count: got %0d want 288", wins); end
    vectors++;
    if (fds != 2) begin miscompares++; $display("FAIL d14_frames: got %0d want 2", fds); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    test_default_14();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
